// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/LS byte-wide RAM port arbiter.
package mem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b11;

    typedef struct packed {
        arb_state_e state;
        arb_owner_e owner;
        logic [2:0] cnt;
        logic [2:0] total;
        logic       ls_pend;
        logic       if_pend;
    } arb_dbg_t;

    // The reserved code 2'b10 is serviced as a full word.
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            LEN_W:   return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-pin bundle of the arbiter; slave is the arbiter side.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    import mem_arbiter_pkg::*;

    // Handshake: dataEn/instEn are one-cycle request pulses with no ready; each is
    // held in a slot until accepted. LOutEn/instOutEn are one-cycle completion
    // pulses with Ldata/inst valid in that same cycle.
    logic                  dataEn;
    logic                  LSRW;
    logic [ADDR_WIDTH-1:0] dataAddr;
    logic [1:0]            LSlen;
    logic [DATA_WIDTH-1:0] Sdata;
    logic                  LOutEn;
    logic [DATA_WIDTH-1:0] Ldata;
    logic                  LSfree;

    logic                  instEn;
    logic [ADDR_WIDTH-1:0] instAddr;
    logic                  instFlush;
    logic                  instOutEn;
    logic [DATA_WIDTH-1:0] inst;

    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;

    arb_dbg_t              dbg;

    modport master (
        output dataEn, LSRW, dataAddr, LSlen, Sdata, instEn, instAddr, instFlush, mem_din,
        input  LOutEn, Ldata, LSfree, instOutEn, inst, mem_dout, mem_a, mem_wr, dbg
    );

    modport slave (
        input  dataEn, LSRW, dataAddr, LSlen, Sdata, instEn, instAddr, instFlush, mem_din,
        output LOutEn, Ldata, LSfree, instOutEn, inst, mem_dout, mem_a, mem_wr, dbg
    );

endinterface

// File: rtl/mem_req_slot.sv
// Single-entry request latch: a new pulse overwrites, accept (clr) empties it.
module mem_req_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         flush,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic         eff_valid,
    output logic [W-1:0] eff_data
);

    logic [W-1:0] q;

    // A load beats a flush at the same edge, so a re-issued request survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= din;
        end else if (flush) begin
            valid <= 1'b0;
        end
    end

    // The view the arbiter accepts from: an arriving pulse is visible in its own cycle.
    assign eff_valid = load | (valid & ~flush);
    assign eff_data  = load ? din : q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and LS requests onto the byte-wide RAM port (LS first) and
// sequences 1/2/4-byte little-endian reads and writes.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int LS_W = 3 + ADDR_WIDTH + DATA_WIDTH;

    arb_state_e            state;
    arb_owner_e            owner;
    logic                  rw;
    logic [2:0]            cnt;
    logic [2:0]            total;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [ADDR_WIDTH-1:0] mem_a_r;
    logic [7:0]            mem_dout_r;
    logic                  mem_wr_r;
    logic                  lout_en_r;
    logic                  inst_out_en_r;
    logic [DATA_WIDTH-1:0] ldata_r;
    logic [DATA_WIDTH-1:0] inst_r;
    logic                  started;

    logic                  ls_valid, ls_eff_valid, ls_take;
    logic [LS_W-1:0]       ls_eff;
    logic                  if_valid, if_eff_valid, if_take;
    logic [ADDR_WIDTH-1:0] if_eff;

    logic                  ls_eff_rw;
    logic [1:0]            ls_eff_len;
    logic [ADDR_WIDTH-1:0] ls_eff_addr;
    logic [DATA_WIDTH-1:0] ls_eff_data;
    logic [2:0]            cnt_m1;
    logic [2:0]            cnt_p1;

    assign ls_take = (state == ARB_IDLE) && ls_eff_valid;
    assign if_take = (state == ARB_IDLE) && !ls_eff_valid && if_eff_valid;

    mem_req_slot #(.W(LS_W)) u_ls_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (bus.dataEn),
        .flush     (1'b0),
        .clr       (ls_take),
        .din       ({bus.LSRW, bus.LSlen, bus.dataAddr, bus.Sdata}),
        .valid     (ls_valid),
        .eff_valid (ls_eff_valid),
        .eff_data  (ls_eff)
    );

    mem_req_slot #(.W(ADDR_WIDTH)) u_if_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (bus.instEn),
        .flush     (bus.instFlush),
        .clr       (if_take),
        .din       (bus.instAddr),
        .valid     (if_valid),
        .eff_valid (if_eff_valid),
        .eff_data  (if_eff)
    );

    assign {ls_eff_rw, ls_eff_len, ls_eff_addr, ls_eff_data} = ls_eff;

    assign cnt_m1 = cnt - 3'd1;
    assign cnt_p1 = cnt + 3'd1;

    // mem_din during BUSY cycle cnt holds the byte addressed in cycle cnt-1.
    always_comb begin
        acc_next = acc;
        if (cnt != 3'd0) begin
            acc_next[{cnt_m1[1:0], 3'b000} +: 8] = bus.mem_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ARB_IDLE;
            owner         <= OWN_IF;
            rw            <= RW_READ;
            cnt           <= '0;
            total         <= '0;
            wdata         <= '0;
            acc           <= '0;
            mem_a_r       <= '0;
            mem_dout_r    <= '0;
            mem_wr_r      <= 1'b0;
            lout_en_r     <= 1'b0;
            inst_out_en_r <= 1'b0;
            ldata_r       <= '0;
            inst_r        <= '0;
            started       <= 1'b0;
        end else begin
            started       <= 1'b1;
            lout_en_r     <= 1'b0;
            inst_out_en_r <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (ls_take) begin
                        state      <= ARB_BUSY;
                        owner      <= OWN_LS;
                        rw         <= ls_eff_rw;
                        cnt        <= '0;
                        total      <= len_to_n(ls_eff_len);
                        wdata      <= ls_eff_data;
                        acc        <= '0;
                        mem_a_r    <= ls_eff_addr;
                        mem_wr_r   <= ls_eff_rw;
                        mem_dout_r <= ls_eff_data[7:0];
                    end else if (if_take) begin
                        state    <= ARB_BUSY;
                        owner    <= OWN_IF;
                        rw       <= RW_READ;
                        cnt      <= '0;
                        total    <= 3'd4;
                        acc      <= '0;
                        mem_a_r  <= if_eff;
                        mem_wr_r <= 1'b0;
                    end
                end
                ARB_BUSY: begin
                    if (owner == OWN_IF && bus.instFlush) begin
                        state <= ARB_IDLE;
                    end else if (rw == RW_WRITE) begin
                        if (cnt == total - 3'd1) begin
                            state     <= ARB_IDLE;
                            mem_wr_r  <= 1'b0;
                            lout_en_r <= 1'b1;
                        end else begin
                            cnt        <= cnt_p1;
                            mem_a_r    <= mem_a_r + ADDR_WIDTH'(1);
                            mem_dout_r <= wdata[{cnt_p1[1:0], 3'b000} +: 8];
                        end
                    end else if (cnt == total) begin
                        // Last byte arrives now; publish the merged word directly.
                        state <= ARB_IDLE;
                        if (owner == OWN_LS) begin
                            ldata_r   <= acc_next;
                            lout_en_r <= 1'b1;
                        end else begin
                            inst_r        <= acc_next;
                            inst_out_en_r <= 1'b1;
                        end
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt_p1;
                        if (cnt_p1 < total) begin
                            mem_a_r <= mem_a_r + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.LOutEn    = lout_en_r;
    assign bus.Ldata     = ldata_r;
    assign bus.instOutEn = inst_out_en_r;
    assign bus.inst      = inst_r;
    assign bus.mem_a     = mem_a_r;
    assign bus.mem_dout  = mem_dout_r;
    assign bus.mem_wr    = mem_wr_r;
    assign bus.LSfree    = started && (state == ARB_IDLE) && !ls_valid;

    assign bus.dbg = '{state: state, owner: owner, cnt: cnt, total: total,
                       ls_pend: ls_valid, if_pend: if_valid};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte RAM model, completion/write scoreboards.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cyc = '0;
    logic [7:0]  ram [0:4095];
    logic [31:0] a;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [63:0] exp_ld_q[$];
    logic [63:0] exp_inst_q[$];
    logic [39:0] exp_wr_q[$];
    logic [31:0] last_ld = '0;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RAM model: read data valid one cycle after its address
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 13 + 7);
        ram[12'h100] = 8'h11;
        ram[12'h101] = 8'h22;
        ram[12'h102] = 8'h33;
        ram[12'h103] = 8'h44;
    end
    always @(posedge clk) bus.mem_din <= ram[bus.mem_a[11:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (bus.LOutEn) begin
            if (exp_ld_q.size() == 0) flag("ls_done_unexpected");
            else check("ls_done", {cyc, bus.Ldata}, exp_ld_q.pop_front());
        end
        if (bus.instOutEn) begin
            if (exp_inst_q.size() == 0) flag("if_done_unexpected");
            else check("if_done", {cyc, bus.inst}, exp_inst_q.pop_front());
        end
        if (bus.mem_wr) begin
            if (exp_wr_q.size() == 0) flag("write_unexpected");
            else check("write", {bus.mem_a, bus.mem_dout}, exp_wr_q.pop_front());
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        bus.dataEn    = 1'b0;
        bus.instEn    = 1'b0;
        bus.instFlush = 1'b0;
    endtask

    task automatic set_ls(input logic rw, input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] d);
        bus.dataEn   = 1'b1;
        bus.LSRW     = rw;
        bus.dataAddr = addr;
        bus.LSlen    = len;
        bus.Sdata    = d;
    endtask

    task automatic set_if(input logic [31:0] addr);
        bus.instEn   = 1'b1;
        bus.instAddr = addr;
    endtask

    task automatic goto(input logic [31:0] t);
        while (cyc < t) tick();
    endtask

    task automatic push_ld(input logic [31:0] done_cyc, input logic [31:0] d);
        exp_ld_q.push_back({done_cyc, d});
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_ld_q.size() + exp_inst_q.size() + exp_wr_q.size()) > 0; i++)
            tick();
        check("drain", 64'(exp_ld_q.size() + exp_inst_q.size() + exp_wr_q.size()), 64'd0);
        tick();
        check("lsfree_idle", 64'(bus.LSfree), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_LOutEn"},    64'(bus.LOutEn),    64'd0);
        check({tag, "_Ldata"},     64'(bus.Ldata),     64'd0);
        check({tag, "_LSfree"},    64'(bus.LSfree),    64'd0);
        check({tag, "_instOutEn"}, 64'(bus.instOutEn), 64'd0);
        check({tag, "_inst"},      64'(bus.inst),      64'd0);
        check({tag, "_mem_a"},     64'(bus.mem_a),     64'd0);
        check({tag, "_mem_dout"},  64'(bus.mem_dout),  64'd0);
        check({tag, "_mem_wr"},    64'(bus.mem_wr),    64'd0);
    endtask

    initial begin
        rst           = 1'b0;
        bus.dataEn    = 1'b0;
        bus.LSRW      = RW_READ;
        bus.dataAddr  = '0;
        bus.LSlen     = LEN_B;
        bus.Sdata     = '0;
        bus.instEn    = 1'b0;
        bus.instAddr  = '0;
        bus.instFlush = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_state", 64'(bus.dbg.state), 64'(ARB_IDLE));
        rst = 1'b1;
        #1;
        check("lsfree_before_edge", 64'(bus.LSfree), 64'd0);
        @(posedge clk);
        #1;
        check("lsfree_after_edge", 64'(bus.LSfree), 64'd1);

        // LW @0x100: done 5 cycles after accept
        tick();
        set_ls(RW_READ, 32'h100, LEN_W, 32'h0);
        a = cyc + 32'd1;
        push_ld(a + 32'd5, 32'h44332211);
        last_ld = 32'h44332211;
        tick();
        check("lsfree_busy", 64'(bus.LSfree), 64'd0);
        drain();

        // LH @0x101
        tick();
        set_ls(RW_READ, 32'h101, LEN_H, 32'h0);
        a = cyc + 32'd1;
        push_ld(a + 32'd3, 32'h00003322);
        last_ld = 32'h00003322;
        drain();

        // SH @0x2FF crossing a page, Ldata must stay untouched
        tick();
        set_ls(RW_WRITE, 32'h2FF, LEN_H, 32'hAABBCCDD);
        a = cyc + 32'd1;
        exp_wr_q.push_back({32'h2FF, 8'hDD});
        exp_wr_q.push_back({32'h300, 8'hCC});
        push_ld(a + 32'd2, last_ld);
        drain();

        // IF and LS at the same edge: LS wins, IF follows with no bubble
        tick();
        set_ls(RW_READ, 32'h40, LEN_B, 32'h0);
        set_if(32'h0);
        a = cyc + 32'd1;
        push_ld(a + 32'd2, 32'h00000047);
        last_ld = 32'h00000047;
        exp_inst_q.push_back({a + 32'd8, 32'h2E211407});
        drain();

        // IF @0x8 flushed in its cycle 2 together with a new fetch @0x20
        tick();
        set_if(32'h8);
        a = cyc + 32'd1;
        goto(a + 32'd2);
        bus.instFlush = 1'b1;
        set_if(32'h20);
        exp_inst_q.push_back({a + 32'd9, 32'hCEC1B4A7});
        drain();

        // LW wrapping through the top of the address space
        tick();
        set_ls(RW_READ, 32'hFFFFFFFE, LEN_W, 32'h0);
        a = cyc + 32'd1;
        push_ld(a + 32'd5, 32'h1407FAED);
        drain();

        // SW interrupted by reset at byte 2
        tick();
        set_ls(RW_WRITE, 32'h500, LEN_W, 32'h01020304);
        a = cyc + 32'd1;
        exp_wr_q.push_back({32'h500, 8'h04});
        exp_wr_q.push_back({32'h501, 8'h03});
        goto(a + 32'd1);
        @(posedge clk);
        #1;
        check("sw_byte2", {31'd0, bus.mem_wr, bus.mem_a}, {31'd0, 1'b1, 32'h502});
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) tick();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("lsfree_after_midreset", 64'(bus.LSfree), 64'd1);
        repeat (6) tick();
        check("sw_writes_seen", 64'(exp_wr_q.size()), 64'd0);

        // recovery after reset
        tick();
        set_ls(RW_READ, 32'h102, LEN_B, 32'h0);
        a = cyc + 32'd1;
        push_ld(a + 32'd2, 32'h00000033);
        drain();

        repeat (4) tick();
        check("final_queues", 64'(exp_ld_q.size() + exp_inst_q.size() + exp_wr_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
